// File: rtl/control_unit_pkg.sv
// Shared types for the core sequencer: states, opcodes, flags
// and the datapath control bundle with its idle value.
package control_signals;

  typedef enum logic [3:0] {
    OP_ALU  = 4'd0,
    OP_SH   = 4'd1,
    OP_LD   = 4'd2,
    OP_ST   = 4'd3,
    OP_LDI  = 4'd4,
    OP_B    = 4'd5,
    OP_ADDI = 4'd6,
    OP_AIPC = 4'd7
  } op_t;

  typedef enum logic [3:0] {
    s_reset, s_fetch, s_alu, s_sh, s_ld, s_st,
    s_ldi, s_b, s_addi, s_aipc, s_ill
  } ctrl_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
  } flags_t;

  typedef enum logic {PCA_ONE, PCA_IR_IMM} pc_adder_sel_t;
  typedef enum logic {PCIN_ADDER, PCIN_SR1OUT} pc_in_sel_t;
  typedef enum logic [1:0] {
    REGIN_ALU_OUT, REGIN_IR_IMM, REGIN_VRAM_OUT
  } reg_in_sel_t;
  typedef enum logic {ALU1_SR1OUT, ALU1_PC} alu_in1_sel_t;
  typedef enum logic [1:0] {
    ALU2_SR2OUT, ALU2_SIMM4, ALU2_SIMM8
  } alu_in2_sel_t;
  typedef enum logic {SR1A_IR_SR1, SR1A_IR_DR} sr1addr_sel_t;
  typedef enum logic {SR2A_IR_SR2, SR2A_IR_DR} sr2addr_sel_t;
  typedef enum logic {VA_ALU_OUT, VA_SR1OUT} vram_addr_sel_t;

  typedef struct packed {
    logic           ld_ir;
    logic           ld_pc;
    logic           reg_w;
    logic           ld_flags;
    logic           rom_active;
    logic           vram_active;
    logic           vram_w;
    pc_adder_sel_t  sel_pc_adder;
    pc_in_sel_t     sel_pc_in;
    reg_in_sel_t    sel_reg_in;
    alu_in1_sel_t   sel_alu_in1;
    alu_in2_sel_t   sel_alu_in2;
    sr1addr_sel_t   sel_sr1addr;
    sr2addr_sel_t   sel_sr2addr;
    vram_addr_sel_t sel_vram_addr;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    ld_ir:         1'b0,
    ld_pc:         1'b0,
    reg_w:         1'b0,
    ld_flags:      1'b0,
    rom_active:    1'b0,
    vram_active:   1'b0,
    vram_w:        1'b0,
    sel_pc_adder:  PCA_ONE,
    sel_pc_in:     PCIN_ADDER,
    sel_reg_in:    REGIN_ALU_OUT,
    sel_alu_in1:   ALU1_SR1OUT,
    sel_alu_in2:   ALU2_SR2OUT,
    sel_sr1addr:   SR1A_IR_SR1,
    sel_sr2addr:   SR2A_IR_SR2,
    sel_vram_addr: VA_ALU_OUT
  };

endpackage

// File: rtl/control_unit_decode.sv
// Opcode to execute-state lookup; unknown opcodes trap to s_ill.
module control_decode
  import control_signals::*;
(
  input  logic [3:0]  i_op,
  output ctrl_state_t o_state
);

  always_comb begin
    o_state = s_ill;
    case (i_op)
      OP_ALU:  o_state = s_alu;
      OP_SH:   o_state = s_sh;
      OP_LD:   o_state = s_ld;
      OP_ST:   o_state = s_st;
      OP_LDI:  o_state = s_ldi;
      OP_B:    o_state = s_b;
      OP_ADDI: o_state = s_addi;
      OP_AIPC: o_state = s_aipc;
      default: o_state = s_ill;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Core sequencer: state register plus the per-state datapath
// control mux, stalling on ROM/VRAM ready handshakes.
module control_unit
  import control_signals::*;
#(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rom_data,
  input  logic          rom_ready,
  input  logic [IW-1:0] ir,
  input  flags_t        flags,
  input  logic          vram_ready,
  output ctrl_t         ctrl,
  output ctrl_state_t   state,
  output logic          ill
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;
  ctrl_state_t w_dec;
  logic [2:0]  w_mask;
  logic        w_ind;
  logic        w_taken;
  logic        w_unused;

  control_decode u_dec (
    .i_op    (rom_data[IW-1:IW-4]),
    .o_state (w_dec)
  );

  assign w_mask   = ir[IW-5:IW-7];
  assign w_ind    = ir[IW-8];
  // mask bits line up with {n,z,c}; empty mask is unconditional
  assign w_taken  = (w_mask == 3'b000) || ((w_mask & flags) != 3'b000);
  assign w_unused = ^{rom_data[IW-5:0], ir[IW-9:0]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= s_reset;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ctrl   = CTRL_DEFAULT;
    unique case (r_state)
      s_reset: w_next = s_fetch;
      s_fetch: begin
        ctrl.rom_active = 1'b1;
        if (rom_ready) begin
          ctrl.ld_ir        = 1'b1;
          ctrl.ld_pc        = 1'b1;
          ctrl.sel_pc_adder = PCA_ONE;
          ctrl.sel_pc_in    = PCIN_ADDER;
          w_next            = w_dec;
        end
      end
      s_alu, s_sh: begin
        ctrl.reg_w       = 1'b1;
        ctrl.sel_reg_in  = REGIN_ALU_OUT;
        ctrl.sel_alu_in1 = ALU1_SR1OUT;
        ctrl.sel_alu_in2 =
          (r_state == s_sh) ? ALU2_SIMM4 : ALU2_SR2OUT;
        ctrl.ld_flags    = 1'b1;
        w_next           = s_fetch;
      end
      s_addi: begin
        ctrl.sel_sr1addr = SR1A_IR_DR;
        ctrl.sel_alu_in2 = ALU2_SIMM8;
        ctrl.reg_w       = 1'b1;
        ctrl.sel_reg_in  = REGIN_ALU_OUT;
        ctrl.ld_flags    = 1'b1;
        w_next           = s_fetch;
      end
      s_aipc: begin
        ctrl.sel_alu_in1 = ALU1_PC;
        ctrl.sel_alu_in2 = ALU2_SIMM8;
        ctrl.reg_w       = 1'b1;
        ctrl.sel_reg_in  = REGIN_ALU_OUT;
        w_next           = s_fetch;
      end
      s_ldi: begin
        ctrl.reg_w      = 1'b1;
        ctrl.sel_reg_in = REGIN_IR_IMM;
        w_next          = s_fetch;
      end
      s_ld: begin
        ctrl.vram_active   = 1'b1;
        ctrl.sel_vram_addr = VA_SR1OUT;
        ctrl.sel_reg_in    = REGIN_VRAM_OUT;
        if (vram_ready) begin
          ctrl.reg_w = 1'b1;
          w_next     = s_fetch;
        end
      end
      s_st: begin
        ctrl.vram_active   = 1'b1;
        ctrl.vram_w        = 1'b1;
        ctrl.sel_vram_addr = VA_SR1OUT;
        ctrl.sel_sr2addr   = SR2A_IR_DR;
        if (vram_ready) w_next = s_fetch;
      end
      s_b: begin
        if (w_taken) begin
          ctrl.ld_pc = 1'b1;
          if (w_ind) begin
            ctrl.sel_pc_in = PCIN_SR1OUT;
          end else begin
            ctrl.sel_pc_adder = PCA_IR_IMM;
            ctrl.sel_pc_in    = PCIN_ADDER;
          end
        end
        w_next = s_fetch;
      end
      s_ill:   w_next = s_ill;
      default: w_next = s_reset;
    endcase
  end

  assign state = r_state;
  assign ill   = (r_state == s_ill);

endmodule
